// File: rtl/decoder_pkg.sv
// decoder_pkg: shared state and mode encodings for the decoder family.
package decoder_pkg;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;
  localparam logic MODE_DECODE = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/onehot_decode.sv
// onehot_decode: combinational SEL_W-to-2^SEL_W one-hot decoder.
module onehot_decode #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      idx,
  output logic [2**SEL_W-1:0]   onehot
);
  localparam int OUT_W = 2**SEL_W;
  assign onehot = OUT_W'(1) << idx;
endmodule

// File: rtl/decoder_scan_nbit.sv
// decoder_scan_nbit: registered one-hot decoder with direct and dwell-timed scan modes.
module decoder_scan_nbit
  import decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int DWELL_W    = 8,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 En,
  input  logic                 Mode,
  input  logic [SEL_W-1:0]     A,
  input  logic [DWELL_W-1:0]   Dwell,
  output logic [2**SEL_W-1:0]  Y,
  output logic [SEL_W-1:0]     Idx,
  output logic                 Wrap
);
  localparam int OUT_W = 2**SEL_W;
  state_t state, nxt_state;
  logic [DWELL_W-1:0] cnt, nxt_cnt;
  logic [SEL_W-1:0] nxt_idx;
  logic [OUT_W-1:0] oh;
  logic adv, nxt_wrap;
  onehot_decode #(.SEL_W(SEL_W)) u_dec (.idx(nxt_idx), .onehot(oh));
  // Next state depends only on En/Mode; the origin state only picks where a scan starts.
  always_comb begin
    nxt_state = !En ? ST_IDLE : Mode == MODE_DECODE ? ST_DECODE : ST_SCAN;
    adv       = state == ST_SCAN && nxt_state == ST_SCAN && cnt >= Dwell;
    nxt_idx   = nxt_state == ST_DECODE ? A
              : (nxt_state == ST_SCAN && state == ST_DECODE) ? '0
              : adv ? Idx + SEL_W'(1) : Idx;
    nxt_cnt   = (state == ST_SCAN && nxt_state == ST_SCAN && !adv) ? cnt + DWELL_W'(1) : '0;
    nxt_wrap  = adv && Idx == '1;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      Idx   <= '0;
      Wrap  <= 1'b0;
      Y     <= {OUT_W{ACTIVE_LOW}};
    end else begin
      state <= nxt_state;
      cnt   <= nxt_cnt;
      Idx   <= nxt_idx;
      Wrap  <= nxt_wrap;
      Y     <= (nxt_state == ST_IDLE ? '0 : oh) ^ {OUT_W{ACTIVE_LOW}};
    end
  end
endmodule

// File: tb/tb_decoder_scan_nbit.sv
// tb_decoder_scan_nbit: randomized and directed checks against a cycle-level behavioural model.
module tb_decoder_scan_nbit;
  localparam int SEL_W = 3;
  localparam int OUT_W = 8;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b0, mode = 1'b0;
  logic [SEL_W-1:0] a = '0;
  logic [7:0] dwell = '0;
  logic [OUT_W-1:0] y, y_lo;
  logic [SEL_W-1:0] idx, idx_lo;
  logic wrap, wrap_lo;
  int tests = 0, fails = 0;
  int m_st, m_idx, m_age;
  bit m_wrap;

  decoder_scan_nbit #(.SEL_W(SEL_W), .DWELL_W(8), .ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .En(en), .Mode(mode), .A(a), .Dwell(dwell),
    .Y(y), .Idx(idx), .Wrap(wrap));
  decoder_scan_nbit #(.SEL_W(SEL_W), .DWELL_W(8), .ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .En(en), .Mode(mode), .A(a), .Dwell(dwell),
    .Y(y_lo), .Idx(idx_lo), .Wrap(wrap_lo));

  always #5 clk = ~clk;

  // m_st: 0 idle, 1 direct, 2 scanning; m_age: cycles the current scan index has been shown.
  function automatic logic [OUT_W-1:0] exp_y();
    return m_st == 0 ? '0 : OUT_W'(1) << m_idx;
  endfunction

  task automatic model_reset();
    m_st = 0; m_idx = 0; m_age = 0; m_wrap = 0;
  endtask

  task automatic tick();
    if (!en) begin m_st = 0; m_wrap = 0; end
    else if (!mode) begin m_st = 1; m_idx = int'(a); m_wrap = 0; end
    else if (m_st != 2) begin
      if (m_st == 1) m_idx = 0;
      m_st = 2; m_age = 1; m_wrap = 0;
    end else if (m_age >= int'(dwell) + 1) begin
      m_idx = (m_idx + 1) % OUT_W; m_age = 1; m_wrap = (m_idx == 0);
    end else begin m_age++; m_wrap = 0; end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; a = 3'b101; mode = 1'b0; dwell = '0;
    model_reset();
    #12;
    tests++; if (y !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin fails++;
      $display("FAIL reset: y=%h idx=%0d wrap=%b expected 00/0/0", y, idx, wrap); end
    tests++; if (y_lo !== 8'hFF) begin fails++;
      $display("FAIL reset_lo: y_lo=%h expected ff", y_lo); end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++; if (y !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0) begin fails++;
        $display("FAIL disabled: y=%h idx=%0d wrap=%b expected 00/0/0", y, idx, wrap); end
    end
  endtask

  task automatic test_decode_sweep();
    en = 1'b1; mode = 1'b0;
    for (int i = 0; i < OUT_W; i++) begin
      a = SEL_W'(i);
      tick();
      tests++; if (y !== OUT_W'(1) << i || idx !== SEL_W'(i) || wrap !== 1'b0) begin fails++;
        $display("FAIL decode a=%0d: y=%h idx=%0d wrap=%b expected %h", i, y, idx, wrap, OUT_W'(1) << i); end
      if (i == 3) begin
        tests++; if (y_lo !== 8'hF7) begin fails++;
          $display("FAIL decode_active_low: y_lo=%h expected f7", y_lo); end
      end
    end
  endtask

  task automatic test_scan_dwell();
    en = 1'b1; mode = 1'b0; a = 3'd6; tick();
    mode = 1'b1; dwell = 8'd2;
    for (int k = 0; k < 50; k++) begin
      tick();
      tests++; if (idx !== SEL_W'((k / 3) % OUT_W) || y !== OUT_W'(1) << ((k / 3) % OUT_W)
                   || wrap !== (k > 0 && k % 24 == 0)) begin fails++;
        $display("FAIL scan_dwell k=%0d: idx=%0d y=%h wrap=%b expected idx %0d", k, idx, y, wrap, (k / 3) % OUT_W); end
    end
  endtask

  task automatic test_scan_full();
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 20; k++) begin
      tick();
      tests++; if (y !== OUT_W'(1) << (k % OUT_W) || wrap !== (k > 0 && k % OUT_W == 0)) begin fails++;
        $display("FAIL scan_full k=%0d: y=%h wrap=%b expected %h", k, y, wrap, OUT_W'(1) << (k % OUT_W)); end
    end
  endtask

  task automatic test_pause_resume();
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 8'd3;
    for (int i = 0; i < 100 && !(m_st == 2 && idx == 3'd5); i++) tick();
    tests++; if (idx !== 3'd5) begin fails++;
      $display("FAIL pause_reach5: idx=%0d expected 5", idx); end
    en = 1'b0; tick();
    tests++; if (y !== 8'h00 || idx !== 3'd5) begin fails++;
      $display("FAIL pause: y=%h idx=%0d expected 00/5", y, idx); end
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      tests++; if (y !== (k < 4 ? 8'h20 : 8'h40)) begin fails++;
        $display("FAIL resume k=%0d: y=%h expected %h", k, y, k < 4 ? 8'h20 : 8'h40); end
    end
  endtask

  task automatic test_mode_switch();
    mode = 1'b0; tick();
    mode = 1'b1; dwell = 8'd0;
    for (int k = 0; k < 5; k++) tick();
    tests++; if (idx !== 3'd4) begin fails++;
      $display("FAIL switch_at4: idx=%0d expected 4", idx); end
    mode = 1'b0; a = 3'd2; tick();
    tests++; if (y !== 8'h04 || idx !== 3'd2) begin fails++;
      $display("FAIL switch_decode: y=%h idx=%0d expected 04/2", y, idx); end
    mode = 1'b1; tick();
    tests++; if (y !== 8'h01 || idx !== 3'd0 || wrap !== 1'b0) begin fails++;
      $display("FAIL switch_rescan: y=%h idx=%0d wrap=%b expected 01/0/0", y, idx, wrap); end
    tick(); tick();
    #2 rst_n = 1'b0; model_reset();
    #1;
    tests++; if (y !== 8'h00 || idx !== 3'd0 || wrap !== 1'b0 || y_lo !== 8'hFF) begin fails++;
      $display("FAIL async_reset: y=%h idx=%0d wrap=%b y_lo=%h expected 00/0/0/ff", y, idx, wrap, y_lo); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      en = $urandom_range(0, 15) != 0;
      if ($urandom_range(0, 9) == 0) mode = ~mode;
      a = SEL_W'($urandom);
      if ($urandom_range(0, 19) == 0) dwell = 8'($urandom_range(0, 4));
      tick();
      tests++; if (y !== exp_y() || idx !== SEL_W'(m_idx) || wrap !== m_wrap || y_lo !== ~exp_y()) begin fails++;
        $display("FAIL random i=%0d: y=%h idx=%0d wrap=%b y_lo=%h expected %h/%0d/%b", i, y, idx, wrap, y_lo, exp_y(), m_idx, m_wrap); end
    end
  endtask

  initial begin
    test_reset();
    test_decode_sweep();
    test_scan_dwell();
    test_scan_full();
    test_pause_resume();
    test_mode_switch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
